// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the MIPS register file.
package regfile_pkg;

  localparam int REGFILE_DEPTH_DEFAULT = 32;
  localparam int REGFILE_WIDTH_DEFAULT = 16;
  localparam int ZERO_REG              = 0;

  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register, out-of-range and optional
// write-through forwarding (REGFILE_BYPASS_EN) rules.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter  int depth = REGFILE_DEPTH_DEFAULT,
  parameter  int width = REGFILE_WIDTH_DEFAULT,
  localparam int AW    = addr_width(depth)
) (
  output logic [width-1:0] read_data,
  input  logic [AW-1:0]    address,
  input  logic [width-1:0] regs [depth]
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic             write_en,
  input  logic [AW-1:0]    write_address,
  input  logic [width-1:0] write_data
`endif
);

  logic address_valid;

  // Index 0 and indices past the last register both read as zero.
  assign address_valid = (int'(address) != ZERO_REG) && (int'(address) < depth);

  always_comb begin
    read_data = '0;
    if (address_valid) begin
      read_data = regs[address];
`ifdef REGFILE_BYPASS_EN
      if (write_en && (write_address == address)) begin
        read_data = write_data;
      end
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with r0 hardwired to zero.
// Optional write-through forwarding enabled by defining REGFILE_BYPASS_EN.
module register_file
  import regfile_pkg::*;
#(
  parameter  int depth = REGFILE_DEPTH_DEFAULT,
  parameter  int width = REGFILE_WIDTH_DEFAULT,
  localparam int AW    = addr_width(depth)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write_en,
  input  logic [AW-1:0]    write_address,
  input  logic [AW-1:0]    read_address_1,
  input  logic [AW-1:0]    read_address_2,
  input  logic [width-1:0] write_data,
  output logic [width-1:0] read_data_1,
  output logic [width-1:0] read_data_2
);

  logic [width-1:0] regs [depth];
  logic             write_ok;

  assign write_ok = write_en && (int'(write_address) != ZERO_REG)
                    && (int'(write_address) < depth);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) begin
        regs[i] <= '0;
      end
    end else if (write_ok) begin
      regs[write_address] <= write_data;
    end
  end

  regfile_read_port #(.depth(depth), .width(width)) u_read_port_1 (
    .read_data     (read_data_1),
    .address       (read_address_1),
    .regs          (regs)
`ifdef REGFILE_BYPASS_EN
    ,
    .write_en      (write_en),
    .write_address (write_address),
    .write_data    (write_data)
`endif
  );

  regfile_read_port #(.depth(depth), .width(width)) u_read_port_2 (
    .read_data     (read_data_2),
    .address       (read_address_2),
    .regs          (regs)
`ifdef REGFILE_BYPASS_EN
    ,
    .write_en      (write_en),
    .write_address (write_address),
    .write_data    (write_data)
`endif
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, writes, r0, write_en gating,
// read-during-write, mid-run reset and out-of-range handling (depth 20 copy).
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        write_en;
  logic [4:0]  write_address;
  logic [4:0]  read_address_1;
  logic [4:0]  read_address_2;
  logic [15:0] write_data;
  logic [15:0] read_data_1;
  logic [15:0] read_data_2;
  logic [15:0] read_data_1_b;
  logic [15:0] read_data_2_b;

  int checks = 0;
  int fails  = 0;

  register_file dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_en       (write_en),
    .write_address  (write_address),
    .read_address_1 (read_address_1),
    .read_address_2 (read_address_2),
    .write_data     (write_data),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2)
  );

  register_file #(.depth(20), .width(16)) dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_en       (write_en),
    .write_address  (write_address),
    .read_address_1 (read_address_1),
    .read_address_2 (read_address_2),
    .write_data     (write_data),
    .read_data_1    (read_data_1_b),
    .read_data_2    (read_data_2_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [15:0] data, input logic en);
    @(negedge clk);
    write_en      = en;
    write_address = addr;
    write_data    = data;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
    read_address_1 = a1;
    read_address_2 = a2;
    #1;
  endtask

  initial begin
    write_en       = 1'b0;
    write_address  = '0;
    write_data     = '0;
    read_address_1 = 5'd1;
    read_address_2 = 5'd31;
    reset_n        = 1'b0;
    #1;
    check("reset_rd1_r1", read_data_1, 16'h0000);
    check("reset_rd2_r31", read_data_2, 16'h0000);
    #1;
    reset_n = 1'b1;

    do_write(5'd1, 16'h0FA0, 1'b1);
    do_write(5'd2, 16'h0FA1, 1'b1);
    do_write(5'd3, 16'h0FA2, 1'b1);
    do_write(5'd4, 16'h0FA3, 1'b1);

    read_pair(5'd0, 5'd1);
    check("read_r0", read_data_1, 16'h0000);
    check("read_r1", read_data_2, 16'h0FA0);
    read_pair(5'd2, 5'd3);
    check("read_r2", read_data_1, 16'h0FA1);
    check("read_r3", read_data_2, 16'h0FA2);
    read_pair(5'd4, 5'd0);
    check("read_r4", read_data_1, 16'h0FA3);
    check("read_r0_p2", read_data_2, 16'h0000);

    // r0 write: checked both while the write is pending and after the edge
    @(negedge clk);
    write_en = 1'b1; write_address = 5'd0; write_data = 16'hFFFF;
    read_pair(5'd0, 5'd1);
    check("r0_during_write", read_data_1, 16'h0000);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    check("r0_after_write", read_data_1, 16'h0000);
    check("r1_untouched", read_data_2, 16'h0FA0);

    for (int i = 0; i < 3; i++) do_write(5'd5, 16'h1234, 1'b0);
    read_pair(5'd5, 5'd4);
    check("we_low_r5", read_data_1, 16'h0000);
    check("we_low_r4", read_data_2, 16'h0FA3);

    do_write(5'd6, 16'h1111, 1'b1);
    @(negedge clk);
    write_en = 1'b1; write_address = 5'd6; write_data = 16'h2222;
    read_pair(5'd6, 5'd6);
`ifdef REGFILE_BYPASS_EN
    check("rdw_before_edge", read_data_1, 16'h2222);
    check("rdw_before_edge_p2", read_data_2, 16'h2222);
`else
    check("rdw_before_edge", read_data_1, 16'h1111);
    check("rdw_before_edge_p2", read_data_2, 16'h1111);
`endif
    @(posedge clk);
    #1;
    write_en = 1'b0;
    check("rdw_after_edge", read_data_1, 16'h2222);
    check("rdw_after_edge_p2", read_data_2, 16'h2222);

    // Reset pulse between edges, with a write edge landing inside it
    @(negedge clk);
    read_pair(5'd1, 5'd6);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_r1", read_data_1, 16'h0000);
    check("midreset_r6", read_data_2, 16'h0000);
    write_en = 1'b1; write_address = 5'd7; write_data = 16'hABCD;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_pair(5'd7, 5'd4);
    check("reset_blocks_write_r7", read_data_1, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_reset_r7", read_data_1, 16'h0000);
    check("post_reset_r4", read_data_2, 16'h0000);

    do_write(5'd2, 16'h5555, 1'b1);
    read_pair(5'd2, 5'd7);
    check("post_reset_write_r2", read_data_1, 16'h5555);
    check("post_reset_r7_still0", read_data_2, 16'h0000);

    // depth-20 copy: index 25 is out of range, 19 is the last register
    do_write(5'd25, 16'h7777, 1'b1);
    do_write(5'd19, 16'h1919, 1'b1);
    read_pair(5'd25, 5'd19);
    check("oor_read_b", read_data_1_b, 16'h0000);
    check("last_reg_b", read_data_2_b, 16'h1919);
    check("r25_full_depth", read_data_1, 16'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Multi-ported general-purpose register file for the 16-bit single-cycle MIPS datapath.
- Two independent combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero, per MIPS convention.
- Sits between instruction decode (read addresses), the ALU (read data) and the writeback mux (write data).

Parameters:
- depth, 32, number of registers; must be at least 2.
- width, 16, bits per register.
- Derived (not overridable): AW = $clog2(depth), the address width.

Ports (positional order is fixed exactly as listed; instantiations rely on it):
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- write_en  input  1  write strobe, sampled on the rising clk edge.
- write_address  input  AW  destination register index.
- read_address_1  input  AW  port-1 source register index.
- read_address_2  input  AW  port-2 source register index.
- write_data  input  width  data to write.
- read_data_1  output  width  contents of register read_address_1.
- read_data_2  output  width  contents of register read_address_2.

Behaviour:
- Reset:
  - reset_n low asynchronously clears all registers to 0.
  - Both read outputs therefore become 0 immediately, with no clock edge needed.
  - Reset dominates any write in progress.
  - Deassertion takes effect from the next rising edge.
- Write:
  - On a rising clk edge with reset_n=1 and write_en=1, reg[write_address] <= write_data.
  - write_en=0: no state change.
- Register 0:
  - Writes to address 0 are ignored.
  - Reads of address 0 always return 0.
- Out-of-range addresses (address >= depth, possible when depth is not a power of 2):
  - Writes are ignored.
  - Reads return 0.
- Read:
  - Purely combinational; read_data_n follows read_address_n and the register contents within the same cycle (zero latency).
  - Both ports are fully independent and may address the same register.
- Read during write (same address, bypass macro absent):
  - Before the edge, the read returns the old value.
  - After the edge, the read returns the new value.
- Write/read widths are exact; no sign or zero extension inside the block.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding on each read port.
  - If write_en=1, write_address equals that port's read address, the address is nonzero and in range, then read_data_n = write_data combinationally in the same cycle.
  - Otherwise the port returns the stored value.
- Undefined: no forwarding; read-during-write behaves exactly as described in Behaviour.

Decomposition:
- Package regfile_pkg:
  - REGFILE_DEPTH_DEFAULT=32, REGFILE_WIDTH_DEFAULT=16.
  - ZERO_REG=0.
  - A function computing address width from depth.
- Sub-module regfile_read_port:
  - Takes address, the storage array, and (with the bypass macro) write-side signals.
  - Produces one read output, applying the zero-register, out-of-range and bypass rules.
  - Instantiated twice.
- Storage and write logic live in the top module.

Test Plan:
- Reset: hold reset_n=0 for 2 ns at time 0, read addresses 1 and 31 -> both outputs 0 with no clock edge.
- Writes: on four consecutive cycles write 0x0FA0→r1, 0x0FA1→r2, 0x0FA2→r3, 0x0FA3→r4; then write_en=0 and read (0,1)→(0x0000,0x0FA0), (2,3)→(0x0FA1,0x0FA2), (4,0)→(0x0FA3,0x0000). Each read pair changes combinationally within 5 ns.
- Zero register: write 0xFFFF to r0 with write_en=1 -> read_data_1 at address 0 stays 0x0000.
- write_en low: present 0x1234→r5 with write_en=0 for 3 cycles -> r5 reads 0x0000.
- Read-during-write on r6 (old value 0x1111, new 0x2222):
  - Macro absent: output 0x1111 before the edge, 0x2222 after.
  - REGFILE_BYPASS_EN defined: output 0x2222 as soon as write_data is applied.
- Reset mid-operation: after the writes above, pulse reset_n low between clock edges -> all reads 0 immediately. A write_en=1 edge during reset leaves the register at 0.
